// File: rtl/instr_unescape_fetch_if.sv
// instr_unescape_fetch_if: byte-stream input and decoded-record output bundle
interface instr_unescape_fetch_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] unescaped_instr;
    logic        is_2byte;
    logic        pfx_opsize;
    logic        pfx_addrsize;
    logic        pfx_lock;
    logic [1:0]  pfx_rep;
    logic [2:0]  pfx_seg;
    logic [3:0]  body_len;
    logic        err;
    modport master (
        output in_byte, in_valid, in_last, out_ready,
        input  in_ready, out_valid, unescaped_instr, is_2byte, pfx_opsize,
               pfx_addrsize, pfx_lock, pfx_rep, pfx_seg, body_len, err
    );
    modport slave (
        input  in_byte, in_valid, in_last, out_ready,
        output in_ready, out_valid, unescaped_instr, is_2byte, pfx_opsize,
               pfx_addrsize, pfx_lock, pfx_rep, pfx_seg, body_len, err
    );
endinterface

// File: rtl/instr_unescape_fetch.sv
// instr_unescape_fetch: strips prefixes and 0x0F escape, packs body bytes into a held record
module instr_unescape_fetch (
    input logic                   clk,
    input logic                   rst_n,
    instr_unescape_fetch_if.slave bus
);
    typedef enum logic [1:0] {PREFIX, BODY, HOLD} state_e;
    typedef struct packed {
        logic [71:0] instr;
        logic        is2;
        logic        opsize;
        logic        addrsize;
        logic        lock;
        logic [1:0]  rep;
        logic [2:0]  seg;
        logic [3:0]  len;
        logic        err;
    } rec_t;
    state_e     state_q;
    rec_t       rec_q;
    logic [2:0] cnt_q;
    logic [7:0] b;
    logic [2:0] seg_c;
    logic       take, esc, pfx;
    always_comb begin
        b     = bus.in_byte;
        take  = bus.in_valid && bus.in_ready;
        seg_c = b == 8'h26 ? 3'd1 : b == 8'h2E ? 3'd2 : b == 8'h36 ? 3'd3 :
                b == 8'h3E ? 3'd4 : b == 8'h64 ? 3'd5 : b == 8'h65 ? 3'd6 : 3'd0;
        esc   = b == 8'h0F;
        pfx   = seg_c != 3'd0 || b == 8'h66 || b == 8'h67 || b == 8'hF0 ||
                b == 8'hF2 || b == 8'hF3;
    end
    assign bus.in_ready        = state_q != HOLD;
    assign bus.out_valid       = state_q == HOLD;
    assign bus.unescaped_instr = rec_q.instr;
    assign bus.is_2byte        = rec_q.is2;
    assign bus.pfx_opsize      = rec_q.opsize;
    assign bus.pfx_addrsize    = rec_q.addrsize;
    assign bus.pfx_lock        = rec_q.lock;
    assign bus.pfx_rep         = rec_q.rep;
    assign bus.pfx_seg         = rec_q.seg;
    assign bus.body_len        = rec_q.len;
    assign bus.err             = rec_q.err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PREFIX;
            rec_q   <= '0;
            cnt_q   <= '0;
        end else if (state_q == HOLD) begin
            if (bus.out_ready) begin
                state_q <= PREFIX;
                rec_q   <= '0;
                cnt_q   <= '0;
            end
        end else if (take) begin
            if (state_q == PREFIX && pfx) begin
                if (cnt_q == 3'd4) rec_q.err <= 1'b1;
                else begin
                    cnt_q          <= cnt_q + 3'd1;
                    rec_q.opsize   <= rec_q.opsize   | (b == 8'h66);
                    rec_q.addrsize <= rec_q.addrsize | (b == 8'h67);
                    rec_q.lock     <= rec_q.lock     | (b == 8'hF0);
                    rec_q.rep      <= b == 8'hF2 ? 2'b10 : b == 8'hF3 ? 2'b11 : rec_q.rep;
                    rec_q.seg      <= seg_c != 3'd0 ? seg_c : rec_q.seg;
                end
            end else if (state_q == PREFIX && esc) begin
                rec_q.is2 <= 1'b1;
                state_q   <= BODY;
            end else if (rec_q.len == 4'd9) rec_q.err <= 1'b1;
            else begin
                rec_q.instr[{rec_q.len, 3'b000} +: 8] <= b;
                rec_q.len <= rec_q.len + 4'd1;
                state_q   <= BODY;
            end
            // completing on a prefix or escape leaves an empty body
            if (bus.in_last) begin
                state_q <= HOLD;
                if (state_q == PREFIX && (pfx || esc)) rec_q.err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_unescape_fetch.sv
// tb_instr_unescape_fetch: directed vectors against hand-computed records
module tb_instr_unescape_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    instr_unescape_fetch_if bus ();
    instr_unescape_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask
    task automatic send(input logic [7:0] b, input logic last);
        int w = 0;
        @(negedge clk);
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w == 20) check("in_ready_timeout", 72'd0, 72'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask
    task automatic accept();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("cleared_valid", {71'd0, bus.out_valid}, 72'd0);
        check("cleared_instr", bus.unescaped_instr, 72'd0);
    endtask
    function automatic logic [71:0] flags();
        return {61'd0, bus.is_2byte, bus.pfx_opsize, bus.pfx_addrsize, bus.pfx_lock,
                bus.pfx_rep, bus.pfx_seg, bus.err};
    endfunction
    initial begin
        bus.in_byte = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        #12 rst_n = 1'b1;
        #1;
        check("rst_ready", {71'd0, bus.in_ready}, 72'd1);
        check("rst_valid", {71'd0, bus.out_valid}, 72'd0);
        check("rst_instr", bus.unescaped_instr, 72'd0);
        // 01 D8
        send(8'h01, 1'b0);
        check("t1_early_valid", {71'd0, bus.out_valid}, 72'd0);
        send(8'hD8, 1'b1);
        check("t1_valid", {71'd0, bus.out_valid}, 72'd1);
        check("t1_instr", bus.unescaped_instr, 72'hD801);
        check("t1_len", {68'd0, bus.body_len}, 72'd2);
        check("t1_flags", flags(), 72'd0);
        accept();
        // 66 F3 0F B8 C0
        send(8'h66, 1'b0); send(8'hF3, 1'b0); send(8'h0F, 1'b0); send(8'hB8, 1'b0); send(8'hC0, 1'b1);
        check("t2_instr", bus.unescaped_instr, 72'hC0B8);
        check("t2_len", {68'd0, bus.body_len}, 72'd2);
        check("t2_flags", flags(), 72'b1_1_0_0_11_000_0);
        accept();
        // F2 F3 2E 64 0F 0F C0
        send(8'hF2, 1'b0); send(8'hF3, 1'b0); send(8'h2E, 1'b0); send(8'h64, 1'b0);
        send(8'h0F, 1'b0); send(8'h0F, 1'b0); send(8'hC0, 1'b1);
        check("t3_instr", bus.unescaped_instr, 72'hC00F);
        check("t3_len", {68'd0, bus.body_len}, 72'd2);
        check("t3_flags", flags(), 72'b1_0_0_0_11_101_0);
        accept();
        // five prefixes then 90
        for (int i = 0; i < 5; i++) send(8'h66, 1'b0);
        send(8'h90, 1'b1);
        check("t4_instr", bus.unescaped_instr, 72'h90);
        check("t4_len", {68'd0, bus.body_len}, 72'd1);
        check("t4_flags", flags(), 72'b0_1_0_0_00_000_1);
        accept();
        // ten body bytes
        for (int i = 1; i <= 10; i++) send(8'(i), i == 10);
        check("t5_instr", bus.unescaped_instr, 72'h090807060504030201);
        check("t5_len", {68'd0, bus.body_len}, 72'd9);
        check("t5_err", {71'd0, bus.err}, 72'd1);
        accept();
        // lone prefix with last
        send(8'h66, 1'b1);
        check("t6_valid", {71'd0, bus.out_valid}, 72'd1);
        check("t6_len", {68'd0, bus.body_len}, 72'd0);
        check("t6_err", {71'd0, bus.err}, 72'd1);
        accept();
        // back-pressure with a pending byte
        send(8'h90, 1'b1);
        @(negedge clk);
        bus.in_byte = 8'h55;
        bus.in_valid = 1'b1;
        bus.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", {71'd0, bus.in_ready}, 72'd0);
            check("bp_instr", bus.unescaped_instr, 72'h90);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_released_valid", {71'd0, bus.out_valid}, 72'd0);
        check("bp_released_ready", {71'd0, bus.in_ready}, 72'd1);
        check("bp_released_instr", bus.unescaped_instr, 72'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        check("bp_next_valid", {71'd0, bus.out_valid}, 72'd1);
        check("bp_next_instr", bus.unescaped_instr, 72'h55);
        accept();
        // reset mid-body
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_instr", bus.unescaped_instr, 72'd0);
        check("mid_rst_len", {68'd0, bus.body_len}, 72'd0);
        check("mid_rst_ready", {71'd0, bus.in_ready}, 72'd1);
        check("mid_rst_valid", {71'd0, bus.out_valid}, 72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'hC3, 1'b1);
        check("post_rst_instr", bus.unescaped_instr, 72'hC3);
        check("post_rst_len", {68'd0, bus.body_len}, 72'd1);
        check("post_rst_flags", flags(), 72'd0);
        accept();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
